// File: rtl/proc_pkg.sv
// Shared datapath definitions for the 16-bit processor: word and register-address
// widths, register count, the condition/control register index and a decoder helper.
package proc_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t CR_IDX = 4'hF;

    // One-hot decode of a register index, qualified by an enable.
    function automatic logic [NUM_REGS-1:0] decodeAddr(input reg_addr_t addr, input logic en);
        logic [NUM_REGS-1:0] oneHot;
        oneHot = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (addr == reg_addr_t'(i))) begin
                oneHot[i] = 1'b1;
            end else begin
                oneHot[i] = 1'b0;
            end
        end
        return oneHot;
    endfunction

endpackage

// File: rtl/reg_file16b16_reg16_en.sv
// Single storage word of the register file: load on enable, cleared
// asynchronously while rstN is low.
module reg16_en
    import proc_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_r;

    // Storage word with async clear and load enable.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data_r <= {WIDTH{1'b0}};
        end else if (en) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/reg_file16b16.sv
// Sixteen-entry general-purpose register file: one clocked write port, two
// combinational read ports and a permanent tap of the condition/control register.
module reg_file16b16
    import proc_pkg::*;
#(
    parameter int        WIDTH   = WORD_W,
    parameter int        DEPTH   = NUM_REGS,
    parameter reg_addr_t CR_ADDR = CR_IDX
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic [WIDTH-1:0]         DataIn,
    input  logic                     Write,
    input  logic [$clog2(DEPTH)-1:0] WriteAddr,
    input  logic [$clog2(DEPTH)-1:0] ReadAddrA,
    input  logic [$clog2(DEPTH)-1:0] ReadAddrB,
    output logic [WIDTH-1:0]         ReadDataA,
    output logic [WIDTH-1:0]         ReadDataB,
    output logic [WIDTH-1:0]         ReadDataCR
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] wrEn_s;
    logic [WIDTH-1:0] regOut_s [DEPTH];
    logic [WIDTH-1:0] readA_s;
    logic [WIDTH-1:0] readB_s;

    // Write-address decoder, each select gated by Write.
    always_comb begin
        wrEn_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (Write && (WriteAddr == AW'(i))) begin
                wrEn_s[i] = 1'b1;
            end else begin
                wrEn_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gRegs
        reg16_en #(
            .WIDTH (WIDTH)
        ) uReg (
            .clk  (CLK),
            .rstN (Reset_n),
            .en   (wrEn_s[g]),
            .d    (DataIn),
            .q    (regOut_s[g])
        );
    end

    // Read multiplexers; no bypass, so a same-cycle write shows after the edge.
    always_comb begin
        readA_s = {WIDTH{1'b0}};
        readB_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (ReadAddrA == AW'(i)) begin
                readA_s = regOut_s[i];
            end else begin
                readA_s = readA_s;
            end
            if (ReadAddrB == AW'(i)) begin
                readB_s = regOut_s[i];
            end else begin
                readB_s = readB_s;
            end
        end
    end

    assign ReadDataA  = readA_s;
    assign ReadDataB  = readB_s;
    assign ReadDataCR = regOut_s[CR_ADDR[AW-1:0]];

endmodule

// File: tb/tb_reg_file16b16.sv
// Directed bench for reg_file16b16: reset, sequential fill, CR tap, write
// enable, read-during-write and asynchronous reset, with hand-computed values.
module tb_reg_file16b16;

    logic        clk;
    logic        rstN;
    logic [15:0] dataIn;
    logic        write;
    logic [3:0]  writeAddr;
    logic [3:0]  readAddrA;
    logic [3:0]  readAddrB;
    logic [15:0] readDataA;
    logic [15:0] readDataB;
    logic [15:0] readDataCR;

    int vecCnt;
    int missCnt;

    reg_file16b16 dut (
        .CLK        (clk),
        .Reset_n    (rstN),
        .DataIn     (dataIn),
        .Write      (write),
        .WriteAddr  (writeAddr),
        .ReadAddrA  (readAddrA),
        .ReadAddrB  (readAddrB),
        .ReadDataA  (readDataA),
        .ReadDataB  (readDataB),
        .ReadDataCR (readDataCR)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            missCnt++;
            $display("FAIL %s: got 16'h%04h, expected 16'h%04h", tag, obs, exp);
        end
    endtask

    // Stimulus and checks.
    initial begin
        vecCnt    = 0;
        missCnt   = 0;
        rstN      = 1'b0;
        write     = 1'b1;
        dataIn    = 16'hFFFF;
        writeAddr = 4'h7;
        readAddrA = 4'h7;
        readAddrB = 4'hF;

        // Reset held with a write attempted across several edges.
        repeat (3) @(posedge clk);
        #1;
        chkVal("rst_a", readDataA, 16'h0000);
        chkVal("rst_b", readDataB, 16'h0000);
        chkVal("rst_cr", readDataCR, 16'h0000);
        @(negedge clk);
        write = 1'b0;
        rstN  = 1'b1;
        #1;
        chkVal("post_rst_a", readDataA, 16'h0000);
        chkVal("post_rst_cr", readDataCR, 16'h0000);

        // Sequential fill.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            dataIn    = 16'(k);
            writeAddr = 4'(k);
            readAddrA = 4'(k);
            write     = 1'b1;
            @(posedge clk);
            #1;
            chkVal($sformatf("fill_a%0d", k), readDataA, 16'(k));
            write     = 1'b0;
            readAddrB = 4'(k + 1);
            #1;
            chkVal($sformatf("fill_b%0d", k), readDataB, 16'h0000);
        end
        @(negedge clk);
        readAddrB = 4'h0;
        #1;
        chkVal("full_b0", readDataB, 16'h0000);
        readAddrB = 4'h9;
        #1;
        chkVal("full_b9", readDataB, 16'h0009);

        // CR tap independent of the read addresses.
        for (int i = 0; i < 3; i++) begin
            readAddrA = 4'(3 * i + 1);
            readAddrB = 4'(5 * i + 2);
            #1;
            chkVal($sformatf("cr_tap%0d", i), readDataCR, 16'h000F);
        end
        readAddrA = 4'hF;
        #1;
        chkVal("cr_via_a", readDataA, 16'h000F);

        @(negedge clk);
        dataIn    = 16'hBEEF;
        writeAddr = 4'hF;
        write     = 1'b1;
        #1;
        chkVal("cr_pre_edge", readDataCR, 16'h000F);
        @(posedge clk);
        #1;
        chkVal("cr_post_edge", readDataCR, 16'hBEEF);
        chkVal("cr_post_a", readDataA, 16'hBEEF);
        write = 1'b0;

        // Write enable off.
        @(negedge clk);
        write     = 1'b0;
        writeAddr = 4'h5;
        dataIn    = 16'hFFFF;
        readAddrA = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        chkVal("wr_off_r5", readDataA, 16'h0005);

        // Read during write on the same register.
        @(negedge clk);
        readAddrA = 4'h3;
        readAddrB = 4'h3;
        writeAddr = 4'h3;
        dataIn    = 16'h1234;
        write     = 1'b1;
        #1;
        chkVal("rdw_pre_a", readDataA, 16'h0003);
        chkVal("rdw_pre_b", readDataB, 16'h0003);
        @(posedge clk);
        #1;
        chkVal("rdw_post_a", readDataA, 16'h1234);
        chkVal("rdw_post_b", readDataB, 16'h1234);
        write = 1'b0;

        // Asynchronous reset between edges.
        @(negedge clk);
        readAddrA = 4'h9;
        readAddrB = 4'h3;
        #1;
        chkVal("pre_async_a", readDataA, 16'h0009);
        #1;
        rstN = 1'b0;
        #1;
        chkVal("async_a", readDataA, 16'h0000);
        chkVal("async_b", readDataB, 16'h0000);
        chkVal("async_cr", readDataCR, 16'h0000);
        @(negedge clk);
        rstN = 1'b1;
        readAddrA = 4'hA;
        #1;
        chkVal("after_async_a", readDataA, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
